dmem_responder: RTL and testbench

Data-memory responder for the 64-bit pipelined core. It sits on the far side of the core's M-stage data port and stores the core's `dataadr`/`writedata` requests into a `2**AW`-entry, 64-bit big-endian array. It returns `readdata` combinationally in the same cycle, as the M stage requires. It also provides:
- a post-reset clearing sequence,
- a valid/ready loader port for boot images,
- a sticky misalignment flag,
- a debug read port.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_lane_sel.sv | 31 +++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM states,
// and byte-lane helpers. Lane k of an entry is bits [8k+7:8k], so byte offset
// 0 (big-endian, entry[63:56]) is lane 7.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_WORD   = 2'b01;
    localparam logic [1:0] SZ_DOUBLE = 2'b10;

    typedef enum logic {CLEAR, RUN} dmem_state_t;

    // Word needs a 4-byte boundary, double an 8-byte boundary; code 11 never fits.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_BYTE:   is_aligned = 1'b1;
            SZ_WORD:   is_aligned = (off[1:0] == 2'b00);
            SZ_DOUBLE: is_aligned = (off == 3'b000);
            default:   is_aligned = 1'b0;
        endcase
    endfunction

    // Byte-enable for a store; all zeros when the access is misaligned.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        if (!is_aligned(size, off)) begin
            lane_mask = 8'h00;
        end else begin
            case (size)
                SZ_BYTE:   lane_mask = 8'h80 >> off;
                SZ_WORD:   lane_mask = off[2] ? 8'h0F : 8'hF0;
                default:   lane_mask = 8'hFF;
            endcase
        end
    endfunction

endpackage

// File: rtl/dmem_lane_sel.sv
// Read-side extraction: picks the addressed byte or word out of a 64-bit
// big-endian entry and right-justifies it. Misaligned accesses read as zero.
module dmem_lane_sel
    import dmem_pkg::*;
(
    input  logic [63:0] entry_i,
    input  logic [1:0]  size_i,
    input  logic [2:0]  off_i,
    output logic [63:0] data_o
);

    logic [5:0]  shamt;
    logic [63:0] shifted;

    // Byte at offset off lives in lane 7-off; shift it down to bits [7:0].
    assign shamt   = {3'd7 - off_i, 3'b000};
    assign shifted = entry_i >> shamt;

    // Select and zero-extend according to access size.
    always_comb begin
        data_o = 64'd0;
        if (is_aligned(size_i, off_i)) begin
            case (size_i)
                SZ_BYTE:   data_o = {56'd0, shifted[7:0]};
                SZ_WORD:   data_o = off_i[2] ? {32'd0, entry_i[31:0]} : {32'd0, entry_i[63:32]};
                default:   data_o = entry_i;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the M-stage data port: 2**AW x 64-bit big-endian
// array with combinational reads, byte-enabled stores, post-reset clearing,
// a boot loader port, a sticky misalignment flag and a debug read port.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int N  = 64,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [1:0]    size,
    input  logic [N-1:0]  dataadr,
    input  logic [N-1:0]  writedata,
    output logic [N-1:0]  readdata,
    output logic          ready,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [N-1:0]  ld_data,
    output logic          misalign,
    input  logic [AW-1:0] checkadr,
    output logic [N-1:0]  checkdata
);

    localparam int DEPTH = 2 ** AW;

    logic [N-1:0]  mem_q [DEPTH];
    dmem_state_t   state_q;
    logic [AW-1:0] cnt_q;
    logic          ready_q;
    logic          misalign_q;

    logic [AW-1:0] idx;
    logic [2:0]    off;
    logic          aligned;
    logic [N-1:0]  sel_data;

    logic          wr_en_d;
    logic [AW-1:0] wr_idx_d;
    logic [N-1:0]  wr_data_d;
    logic [7:0]    wr_mask_d;

    // Address bits above the entry index alias and are intentionally dropped.
    logic unused_hi;
    assign unused_hi = ^dataadr[N-1:AW+3];

    assign idx     = dataadr[AW+2:3];
    assign off     = dataadr[2:0];
    assign aligned = is_aligned(size, off);

    // Loader handshake: a transfer happens on a rising edge where ld_valid and
    // ld_ready are both high. ld_ready is low during CLEAR and whenever the
    // core stores (core has priority); the loader holds ld_valid/ld_addr/
    // ld_data stable until the transfer happens.
    assign ld_ready = (state_q == RUN) && !memwrite;

    assign ready     = ready_q;
    assign misalign  = misalign_q;
    assign checkdata = mem_q[checkadr];

    dmem_lane_sel u_lane_sel (
        .entry_i (mem_q[idx]),
        .size_i  (size),
        .off_i   (off),
        .data_o  (sel_data)
    );

    assign readdata = (state_q == RUN) ? sel_data : '0;

    // Single write port arbitration: clearing, then core store, then loader.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_idx_d  = '0;
        wr_data_d = '0;
        wr_mask_d = 8'h00;
        if (!reset) begin
            if (state_q == CLEAR) begin
                wr_en_d   = 1'b1;
                wr_idx_d  = cnt_q;
                wr_mask_d = 8'hFF;
            end else if (memwrite) begin
                wr_en_d  = aligned;
                wr_idx_d = idx;
                wr_mask_d = lane_mask(size, off);
                case (size)
                    SZ_BYTE: wr_data_d = {8{writedata[7:0]}};
                    SZ_WORD: wr_data_d = {2{writedata[31:0]}};
                    default: wr_data_d = writedata;
                endcase
            end else if (ld_valid) begin
                wr_en_d   = 1'b1;
                wr_idx_d  = ld_addr;
                wr_data_d = ld_data;
                wr_mask_d = 8'hFF;
            end
        end
    end

    // Array update with per-lane byte enables; untouched lanes keep their value.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            for (int k = 0; k < 8; k++) begin
                if (wr_mask_d[k]) begin
                    mem_q[wr_idx_d][8*k +: 8] <= wr_data_d[8*k +: 8];
                end
            end
        end
    end

    // CLEAR/RUN FSM with clear counter, registered ready and sticky misalign.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    if (memwrite && !aligned) begin
                        misalign_q <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with AW = 4 (16 entries).
module tb_dmem_responder;

    localparam int N  = 64;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          memwrite;
    logic [1:0]    size;
    logic [N-1:0]  dataadr;
    logic [N-1:0]  writedata;
    logic [N-1:0]  readdata;
    logic          ready;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [N-1:0]  ld_data;
    logic          misalign;
    logic [AW-1:0] checkadr;
    logic [N-1:0]  checkdata;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .size      (size),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .ready     (ready),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .misalign  (misalign),
        .checkadr  (checkadr),
        .checkdata (checkdata)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Combinational core read: set inputs, settle, compare.
    task automatic read_chk(input string tag, input logic [1:0] sz, input logic [63:0] adr,
                            input logic [63:0] exp);
        size = sz;
        dataadr = adr;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic store(input logic [1:0] sz, input logic [63:0] adr, input logic [63:0] wd);
        memwrite = 1'b1;
        size = sz;
        dataadr = adr;
        writedata = wd;
        step();
        memwrite = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; memwrite = 1'b0; size = 2'b00; dataadr = '0; writedata = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; checkadr = '0;
        step();
        step();
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
        check("rst_misalign", {63'd0, misalign}, 64'd0);

        // Test 1: clearing takes 16 cycles; a store at cycle 5 to entry 0 is ignored.
        reset = 1'b0;
        size = 2'b10; dataadr = 64'h10;
        #1;
        check("clear_readdata", readdata, 64'd0);
        check("clear_ld_ready", {63'd0, ld_ready}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("clear_ready_%0d", i), {63'd0, ready}, 64'd0);
            if (i == 5) begin
                memwrite = 1'b1; size = 2'b10; dataadr = 64'h0; writedata = 64'hFFFF_FFFF_FFFF_FFFF;
            end else begin
                memwrite = 1'b0;
            end
            step();
        end
        memwrite = 1'b0;
        check("ready_after_clear", {63'd0, ready}, 64'd1);
        check("misalign_after_clear", {63'd0, misalign}, 64'd0);
        for (int e = 0; e < 16; e++) begin
            checkadr = AW'(e);
            #1;
            check($sformatf("cleared_%0d", e), checkdata, 64'd0);
        end

        // Test 2: double store then byte/word loads, plus aliasing.
        store(2'b10, 64'h10, 64'h0011223344556677);
        read_chk("byte_13", 2'b00, 64'h13, 64'h33);
        read_chk("word_14", 2'b01, 64'h14, 64'h44556677);
        read_chk("byte_10", 2'b00, 64'h10, 64'h00);
        read_chk("byte_17", 2'b00, 64'h17, 64'h77);
        read_chk("word_10", 2'b01, 64'h10, 64'h00112233);
        read_chk("alias_90", 2'b10, 64'h90, 64'h0011223344556677);

        // Test 3: byte store only touches its lane.
        store(2'b00, 64'h15, 64'hFFFF_FFFF_FFFF_FFAB);
        read_chk("dbl_after_byte", 2'b10, 64'h10, 64'h0011223344AB6677);

        // Same-cycle store and load of one entry returns old data.
        memwrite = 1'b1; size = 2'b01; dataadr = 64'h10; writedata = 64'h11111111_CAFEBABE;
        #1;
        check("rd_during_wr", readdata, 64'h00112233);
        step();
        memwrite = 1'b0;
        read_chk("dbl_after_word", 2'b10, 64'h10, 64'hCAFEBABE44AB6677);

        // Misaligned reads return zero.
        read_chk("misal_rd_word", 2'b01, 64'h12, 64'd0);
        read_chk("misal_rd_sz11", 2'b11, 64'h10, 64'd0);

        // Test 4: loader blocked by a core store, accepted next cycle.
        ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 64'hDEADBEEF_DEADBEEF;
        memwrite = 1'b1; size = 2'b10; dataadr = 64'h28; writedata = 64'h0101010101010101;
        #1;
        check("ld_blocked", {63'd0, ld_ready}, 64'd0);
        step();
        memwrite = 1'b0;
        #1;
        check("ld_accept", {63'd0, ld_ready}, 64'd1);
        checkadr = 4'd3;
        #1;
        check("ld_not_yet", checkdata, 64'd0);
        step();
        ld_valid = 1'b0;
        #1;
        check("ld_data_3", checkdata, 64'hDEADBEEF_DEADBEEF);
        checkadr = 4'd5;
        #1;
        check("store_5", checkdata, 64'h0101010101010101);

        // Test 5: misaligned word store sets the sticky flag, array unchanged.
        store(2'b01, 64'h22, 64'hFFFF_FFFF_FFFF_FFFF);
        checkadr = 4'd4;
        #1;
        check("misal_set", {63'd0, misalign}, 64'd1);
        check("misal_no_write", checkdata, 64'd0);
        store(2'b10, 64'h30, 64'h1234);
        step();
        check("misal_sticky", {63'd0, misalign}, 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("misal_cleared", {63'd0, misalign}, 64'd0);
        check("rerun_clear", {63'd0, ready}, 64'd0);

        // Test 6: reset at cnt = 7 restarts a full clear.
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        #1;
        while (!ready && n < 40) begin
            step();
            n++;
        end
        check("restart_cycles", 64'(n), 64'd16);
        checkadr = 4'd3;
        #1;
        check("recleared_3", checkdata, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
